fp_hex_scroller: RTL and testbench
==================================

FP_HEX_SCROLLER -- requirements
Module: fp_hex_scroller

Interface
REQ-001 Parameter TICKS_PER_STEP, default 50000000, sets the clock cycles each display step is held; legal values are 2 or more.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data_in  input  32  word to display, normally the FP adder result.
REQ-005 data_valid  input  1  when 1, data_in is captured on this clock edge.
REQ-006 seg1  output  7  high-nibble digit, active-low; bit 6 = a down to bit 0 = g.
REQ-007 seg0  output  7  low-nibble digit, same encoding as seg1.
REQ-008 an1  output  1  digit-1 enable, active-low.
REQ-009 an0  output  1  digit-0 enable, active-low.
REQ-010 byte_sel  output  2  index of the byte shown: 3 = bits [31:24], 0 = bits [7:0].
REQ-011 blank  output  1  1 when neither digit shows data.

Function
REQ-012 The block SHALL have three states: IDLE (no data captured), SHOW (one byte displayed) and GAP (one blank step).
REQ-013 When data_valid=1 in any state, the block SHALL capture data_in into a shadow register, enter SHOW with byte_sel=3 and clear the step counter.
REQ-014 All outputs SHALL be registered, so the first SHOW display appears on the cycle after the capture edge.
REQ-015 In SHOW, seg1 SHALL display the high nibble and seg0 the low nibble of the selected byte, an1=an0=0 and blank=0.
REQ-016 Each SHOW step and the GAP step SHALL last exactly TICKS_PER_STEP cycles.
REQ-017 Step order SHALL be byte 3, 2, 1, 0, then GAP, then byte 3 again, repeating indefinitely with a period of 5*TICKS_PER_STEP cycles.
REQ-018 In IDLE and GAP the block SHALL drive seg1=seg0=7'h7F, an1=an0=1 and blank=1; byte_sel SHALL hold 3.
REQ-019 The hex encoding (active-low) SHALL be:
- 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
- 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
REQ-020 If data_valid coincides with a step-expiry edge, the load SHALL win: the new word is shown at byte 3 with a full-length step.
REQ-021 Repeated data_valid with identical data SHALL restart the sequence at byte 3.
REQ-022 Changes on data_in while data_valid=0 SHALL have no effect on the outputs.
REQ-023 The step counter SHALL be the minimum width holding TICKS_PER_STEP-1 and SHALL wrap to 0 at step expiry without overflow.

Reset
REQ-024 While rst=1, the block SHALL enter IDLE on the next edge and clear the counter and shadow register to 0, with seg1=seg0=7'h7F, an1=an0=1, byte_sel=3 and blank=1.
REQ-025 rst SHALL override a simultaneous data_valid.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence with no residual state.

Configuration
REQ-027 With macro FP_HEX_SCROLLER_HOLD_EN defined, the block SHALL add a port hold (input, 1 bit).
REQ-028 With FP_HEX_SCROLLER_HOLD_EN defined, while hold=1 the step counter and state SHALL freeze and the current display SHALL persist.
REQ-029 With FP_HEX_SCROLLER_HOLD_EN defined, data_valid SHALL still load and restart the sequence while hold=1, and the sequence stays frozen at byte 3.
REQ-030 With FP_HEX_SCROLLER_HOLD_EN undefined, the hold port SHALL be absent and the block SHALL behave as if hold=0.

Verification (TICKS_PER_STEP=4)
REQ-031 Reset then idle -> blank=1 with segs 7F/7F until data_valid.
REQ-032 Load 32'h6b64b235 then 32'h6ba37d9f -> the second word is shown, restarting at byte 3.
REQ-033 Load 32'h6ba37d9f -> seg1/seg0 show 20/60 (cycles 1-4), 08/06 (cycles 5-8), 0F/42 (cycles 9-12), 04/38 (cycles 13-16), then blank 7F/7F (cycles 17-20), then 20/60 again at cycle 21.
REQ-034 During the 0F/42 step, load 32'h0123CDEF on the expiry edge -> 01/4F shown next, held for 4 cycles.
REQ-035 With 32'h6ba37d9f loaded, assert rst during byte 1 -> next cycle IDLE, blank=1, byte_sel=3; no further steps until a new load.
REQ-036 With FP_HEX_SCROLLER_HOLD_EN defined, assert hold=1 for 10 cycles during byte 2 -> 08/06 shown for 14 cycles total.

Source files
------------

// File: rtl/fp_hex_scroller.sv
// Scrolls a captured 32-bit word across a two-digit seven-segment display, one byte per step, then one blank step.
// Optional macro FP_HEX_SCROLLER_HOLD_EN adds a 'hold' input that freezes the scroll.
module fp_hex_scroller #(
  parameter int unsigned TICKS_PER_STEP = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
`ifdef FP_HEX_SCROLLER_HOLD_EN
  input  logic        hold,
`endif
  output logic [6:0]  seg1,
  output logic [6:0]  seg0,
  output logic        an1,
  output logic        an0,
  output logic [1:0]  byte_sel,
  output logic        blank,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      shadow_q, shadow_d;

  logic [6:0]       seg1_q, seg1_d;
  logic [6:0]       seg0_q, seg0_d;
  logic             an1_q, an1_d;
  logic             an0_q, an0_d;
  logic [1:0]       byte_sel_q, byte_sel_d;
  logic             blank_q, blank_d;

  logic             hold_w;
  logic             step_done;
  logic [7:0]       sel_byte;

`ifdef FP_HEX_SCROLLER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign step_done = (cnt_q == CNT_LAST);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // State register: all state and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= 2'd3;
      shadow_q   <= '0;
      seg1_q     <= SEG_OFF;
      seg0_q     <= SEG_OFF;
      an1_q      <= 1'b1;
      an0_q      <= 1'b1;
      byte_sel_q <= 2'd3;
      blank_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      seg1_q     <= seg1_d;
      seg0_q     <= seg0_d;
      an1_q      <= an1_d;
      an0_q      <= an0_d;
      byte_sel_q <= byte_sel_d;
      blank_q    <= blank_d;
    end
  end

  // Next state: a load always wins, even over step expiry and hold.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    if (data_valid) begin
      shadow_d = data_in;
      state_d  = ST_SHOW;
      byte_d   = 2'd3;
      cnt_d    = '0;
    end else if (!hold_w) begin
      case (state_q)
        ST_SHOW: begin
          if (step_done) begin
            cnt_d = '0;
            if (byte_q == 2'd0) begin
              state_d = ST_GAP;
              byte_d  = 2'd3;
            end else begin
              byte_d = byte_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (step_done) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            byte_d  = 2'd3;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          byte_d  = 2'd3;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the display changes on the same edge as the state.
  always_comb begin
    case (byte_d)
      2'd3:    sel_byte = shadow_d[31:24];
      2'd2:    sel_byte = shadow_d[23:16];
      2'd1:    sel_byte = shadow_d[15:8];
      default: sel_byte = shadow_d[7:0];
    endcase
    seg1_d     = SEG_OFF;
    seg0_d     = SEG_OFF;
    an1_d      = 1'b1;
    an0_d      = 1'b1;
    byte_sel_d = 2'd3;
    blank_d    = 1'b1;
    if (state_d == ST_SHOW) begin
      seg1_d     = hex_to_seg(sel_byte[7:4]);
      seg0_d     = hex_to_seg(sel_byte[3:0]);
      an1_d      = 1'b0;
      an0_d      = 1'b0;
      byte_sel_d = byte_d;
      blank_d    = 1'b0;
    end
  end

  assign seg1      = seg1_q;
  assign seg0      = seg0_q;
  assign an1       = an1_q;
  assign an0       = an0_q;
  assign byte_sel  = byte_sel_q;
  assign blank     = blank_q;
  assign dbg_state = state_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_LAST);
  a_blank_an:  assert property (@(posedge clk) disable iff (rst) (blank_q == an1_q) && (blank_q == an0_q));
  a_show_lit:  assert property (@(posedge clk) disable iff (rst) (state_q == ST_SHOW) |-> !blank_q);
  a_gap_sel:   assert property (@(posedge clk) disable iff (rst) (state_q != ST_SHOW) |-> (byte_sel_q == 2'd3));

endmodule

// File: tb/tb_fp_hex_scroller.sv
// Bench for fp_hex_scroller with TICKS_PER_STEP=4: step-position model checked every cycle plus literal display checks.
module tb_fp_hex_scroller;
  localparam int T = 4;
  localparam int PERIOD = 5 * T;
  localparam int W = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic        hold;
  logic [31:0] data_in;
  logic [6:0]  seg1, seg0;
  logic        an1, an0, blank;
  logic [1:0]  byte_sel, dbg_state;

  int checks = 0;
  int errors = 0;

  logic [6:0]   enc_t [16];
  logic [W-1:0] exp_q [$];

  logic        m_loaded = 1'b0;
  int          m_pos = 0;
  logic [31:0] m_word = '0;

  fp_hex_scroller #(.TICKS_PER_STEP(T)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
`ifdef FP_HEX_SCROLLER_HOLD_EN
    .hold(hold),
`endif
    .seg1(seg1),
    .seg0(seg0),
    .an1(an1),
    .an0(an0),
    .byte_sel(byte_sel),
    .blank(blank),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_out(input logic loaded, input int pos, input logic [31:0] w);
    int step;
    logic [1:0] b;
    logic [7:0] by;
    if (!loaded) return {7'h7F, 7'h7F, 1'b1, 1'b1, 2'd3, 1'b1};
    step = pos / T;
    if (step == 4) return {7'h7F, 7'h7F, 1'b1, 1'b1, 2'd3, 1'b1};
    b  = 2'(3 - step);
    by = 8'(w >> (8 * b));
    return {enc_t[by[7:4]], enc_t[by[3:0]], 1'b0, 1'b0, b, 1'b0};
  endfunction

  // model: position within the 5-step cycle since the last load
  always @(posedge clk) begin
    if (rst) begin
      m_loaded = 1'b0;
      m_pos    = 0;
      m_word   = '0;
    end else if (data_valid) begin
      m_loaded = 1'b1;
      m_word   = data_in;
      m_pos    = 0;
    end else if (m_loaded && !hold) begin
      m_pos = (m_pos + 1) % PERIOD;
    end
    exp_q.push_back(model_out(m_loaded, m_pos, m_word));
  end

  // scoreboard compare
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {seg1, seg0, an1, an0, byte_sel, blank};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [6:0] s1, input logic [6:0] s0,
                     input logic [1:0] bs, input logic b);
    logic [W-1:0] a, e;
    a = {seg1, seg0, an1, an0, byte_sel, blank};
    e = {s1, s0, b, b, bs, b};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in = $urandom;
    end
  endtask

  task automatic load(input logic [31:0] w);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = $urandom;
  endtask

  initial begin
    int n;
    enc_t = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    rst = 1'b1; data_valid = 1'b0; data_in = '0; hold = 1'b0;
    step(3);
    lit("reset", 7'h7F, 7'h7F, 2'd3, 1'b1);
    rst = 1'b0;
    step(6);
    lit("idle", 7'h7F, 7'h7F, 2'd3, 1'b1);

    // second load replaces the first and restarts at byte 3
    load(32'h6b64b235);
    step(2);
    load(32'h6ba37d9f);
    lit("seq_b3", 7'h20, 7'h60, 2'd3, 1'b0);
    step(4); lit("seq_b2", 7'h08, 7'h06, 2'd2, 1'b0);
    step(4); lit("seq_b1", 7'h0F, 7'h42, 2'd1, 1'b0);
    step(4); lit("seq_b0", 7'h04, 7'h38, 2'd0, 1'b0);
    step(4); lit("seq_gap", 7'h7F, 7'h7F, 2'd3, 1'b1);
    step(3); lit("seq_gap_end", 7'h7F, 7'h7F, 2'd3, 1'b1);
    step(1); lit("seq_wrap", 7'h20, 7'h60, 2'd3, 1'b0);

    // load on the expiry edge of byte 1
    load(32'h6ba37d9f);
    step(8); lit("exp_b1", 7'h0F, 7'h42, 2'd1, 1'b0);
    step(3);
    load(32'h0123CDEF);
    lit("exp_load", 7'h01, 7'h4F, 2'd3, 1'b0);
    step(3); lit("exp_full", 7'h01, 7'h4F, 2'd3, 1'b0);
    step(1); lit("exp_next", 7'h12, 7'h06, 2'd2, 1'b0);

    // identical reload restarts with a full step
    step(2);
    load(32'h0123CDEF);
    lit("same_b3", 7'h01, 7'h4F, 2'd3, 1'b0);
    step(3); lit("same_full", 7'h01, 7'h4F, 2'd3, 1'b0);
    step(1); lit("same_next", 7'h12, 7'h06, 2'd2, 1'b0);

    // reset mid-sequence
    load(32'h6ba37d9f);
    step(9);
    rst = 1'b1;
    step(1);
    lit("rst_mid", 7'h7F, 7'h7F, 2'd3, 1'b1);
    rst = 1'b0;
    step(25);
    lit("rst_stays", 7'h7F, 7'h7F, 2'd3, 1'b1);

    // reset beats a simultaneous load
    load(32'h89ABCDEF);
    rst = 1'b1; data_valid = 1'b1; data_in = 32'h6ba37d9f;
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    lit("rst_vs_load", 7'h7F, 7'h7F, 2'd3, 1'b1);
    step(6);
    lit("rst_vs_load_idle", 7'h7F, 7'h7F, 2'd3, 1'b1);

`ifdef FP_HEX_SCROLLER_HOLD_EN
    load(32'h6ba37d9f);
    step(4);
    n = 0;
    while (seg1 == 7'h08 && seg0 == 7'h06 && n < 40) begin
      n++;
      if (n == 1) hold = 1'b1;
      if (n == 11) hold = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL hold_len actual=%0d required=14", n);
    end
    hold = 1'b1;
    load(32'h0123CDEF);
    step(6); lit("hold_load", 7'h01, 7'h4F, 2'd3, 1'b0);
    hold = 1'b0;
    step(4); lit("hold_release", 7'h12, 7'h06, 2'd2, 1'b0);
`endif

    // free run through several full periods against the model
    load(32'hFEDCBA98);
    lit("free_b3", 7'h38, 7'h30, 2'd3, 1'b0);
    step(2 * PERIOD + 3);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
